conv_ctrl: RTL and testbench
============================

CONV_CTRL -- requirements
Module: conv_ctrl

Interface
REQ-001 SHALL have parameter BIT_LEN, default 8, pixel/coefficient width.
REQ-002 SHALL have parameter OUT_LEN, default 13, convolver result width.
REQ-003 SHALL have parameter IMG_W, default 64, columns per strip, legal range 3..1024.
REQ-004 SHALL have parameter N_STRIP, default 62, strips per frame (image rows minus 2), legal range 1..1024.
REQ-005 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have port i_start, input, 1, one-cycle frame start request.
REQ-008 SHALL have port s_valid, input, 1, stream word valid.
REQ-009 SHALL have port s_ready, output, 1, stream word accepted when s_valid and s_ready are both high.
REQ-010 SHALL have port s_data, input, 3*BIT_LEN, one column {d2,d1,d0}; kernel columns first, then image columns.
REQ-011 SHALL have port o_conv_valid, output, 1, convolver shift/latch strobe.
REQ-012 SHALL have port o_conv_sel, output, 1, 0 = kernel load, 1 = image.
REQ-013 SHALL have ports o_conv_d0, o_conv_d1, o_conv_d2, output, BIT_LEN each, column to convolver.
REQ-014 SHALL have port i_conv_data, input, OUT_LEN, registered convolver result.
REQ-015 SHALL have ports m_valid (output, 1) and m_data (output, OUT_LEN), result stream with no backpressure.
REQ-016 SHALL have ports o_busy (output, 1) and o_done (output, 1); o_done is a one-cycle end-of-frame pulse.

Function
REQ-017 SHALL implement FSM IDLE -> LOAD_K -> RUN -> FLUSH -> (RUN | DONE) -> IDLE.
REQ-018 IDLE: s_ready=0, o_busy=0; i_start moves the FSM to LOAD_K and clears the kernel, column and strip counters.
REQ-019 LOAD_K: s_ready=1, o_conv_sel=0; exactly 3 accepted words are forwarded, then the FSM enters RUN.
REQ-020 RUN: s_ready=1, o_conv_sel=1; exactly IMG_W accepted words are forwarded per strip, then the FSM enters FLUSH.
REQ-021 In LOAD_K and RUN, o_conv_valid SHALL equal s_valid AND s_ready, and o_conv_d0/d1/d2 SHALL be combinational slices of s_data (zero added latency).
REQ-022 FLUSH: exactly one cycle; o_conv_valid=1, o_conv_sel=1, data all zero, s_ready=0.
REQ-023 After FLUSH, the FSM SHALL go to RUN if the strip count is below N_STRIP, else to DONE.
REQ-024 DONE: one cycle; o_done=1, s_ready=0; then IDLE.
REQ-025 An image beat is capturing when its 0-based column index is >=3, or when it is the FLUSH beat.
REQ-026 m_valid SHALL pulse exactly one cycle after each capturing beat, with m_data=i_conv_data in that cycle; this gives IMG_W-2 results per strip.
REQ-027 Beats at column indices 0..2 SHALL NOT produce m_valid.
REQ-028 s_valid low SHALL stall counters and FSM with no timeout; o_conv_valid stays 0 while stalled.
REQ-029 i_start while o_busy=1 SHALL be ignored.
REQ-030 o_busy=1 in LOAD_K, RUN and FLUSH, 0 in IDLE and DONE.
REQ-031 Column counter SHALL be $clog2(IMG_W+1) bits and strip counter $clog2(N_STRIP+1) bits; both wrap to 0 at strip/frame end.

Reset
REQ-032 rst SHALL force IDLE, clear all counters, and drive s_ready=0, o_conv_valid=0, o_conv_sel=0, m_valid=0, m_data=0, o_busy=0, o_done=0.
REQ-033 rst mid-frame SHALL abort with no further m_valid; partially loaded kernel state is not restored.

Structure
REQ-034 FSM state encoding and default BIT_LEN/OUT_LEN SHALL live in shared package conv_pkg.
REQ-035 The block SHALL be a single module plus one sub-module, conv_ctrl_cnt, a parameterised enable/clear/terminal-count counter instantiated for column, kernel-beat and strip counts.

Verification
REQ-036 Kernel columns {0,0,0},{0,1,0},{0,0,0}, IMG_W=5, N_STRIP=1, image columns with d1=10,20,30,40,50 -> m_data=20,30,40 (3 pulses), then o_done.
REQ-037 Same run with s_valid toggled every other cycle -> identical m_data sequence, and no o_conv_valid while s_valid=0.
REQ-038 N_STRIP=2, IMG_W=4 -> exactly 4 m_valid pulses, one FLUSH per strip, o_done once.
REQ-039 i_start pulsed during RUN -> no effect on counts or outputs.
REQ-040 rst asserted after the 2nd image beat -> next cycle IDLE, all outputs 0; a new i_start then runs a full frame correctly.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolver stream controller: FSM encoding and default widths.
package conv_pkg;

  localparam int DEF_BIT_LEN = 8;
  localparam int DEF_OUT_LEN = 13;
  localparam int KERN_COLS   = 3;
  // First image column whose beat yields a complete 3-column window result
  localparam int CAPTURE_COL = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_K,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } state_t;

endpackage

// File: rtl/conv_ctrl_cnt.sv
// Enable/clear counter that wraps to zero after reaching its terminal value.
module conv_ctrl_cnt #(
  parameter int WIDTH = 4,
  parameter int TERM  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic at_term;

  assign at_term = (count == WIDTH'(TERM));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= at_term ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/conv_ctrl.sv
// Streams kernel then image columns into a 3x3 convolver and re-times its results onto m_valid/m_data.
module conv_ctrl
  import conv_pkg::*;
#(
  parameter int BIT_LEN = DEF_BIT_LEN,
  parameter int OUT_LEN = DEF_OUT_LEN,
  parameter int IMG_W   = 64,
  parameter int N_STRIP = 62
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [3*BIT_LEN-1:0] s_data,
  output logic                 o_conv_valid,
  output logic                 o_conv_sel,
  output logic [BIT_LEN-1:0]   o_conv_d0,
  output logic [BIT_LEN-1:0]   o_conv_d1,
  output logic [BIT_LEN-1:0]   o_conv_d2,
  input  logic [OUT_LEN-1:0]   i_conv_data,
  output logic                 m_valid,
  output logic [OUT_LEN-1:0]   m_data,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int COL_W   = $clog2(IMG_W + 1);
  localparam int STRIP_W = $clog2(N_STRIP + 1);
  localparam int KERN_W  = $clog2(KERN_COLS + 1);

  state_t state, state_nx;

  logic               beat;
  logic               cnt_clr;
  logic               kern_en, col_en, strip_en;
  logic [KERN_W-1:0]  kern_cnt;
  logic [COL_W-1:0]   col_cnt;
  logic [STRIP_W-1:0] strip_cnt;
  logic               kern_last, col_last, strip_last;
  logic               capture_p0;
  logic               vld_p1;

  assign beat       = s_valid && s_ready;
  assign kern_last  = (kern_cnt == KERN_W'(KERN_COLS - 1));
  assign col_last   = (col_cnt == COL_W'(IMG_W - 1));
  assign strip_last = (strip_cnt == STRIP_W'(N_STRIP - 1));

  conv_ctrl_cnt #(.WIDTH(KERN_W), .TERM(KERN_COLS - 1)) u_kern_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .en(kern_en), .count(kern_cnt)
  );

  conv_ctrl_cnt #(.WIDTH(COL_W), .TERM(IMG_W - 1)) u_col_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .en(col_en), .count(col_cnt)
  );

  conv_ctrl_cnt #(.WIDTH(STRIP_W), .TERM(N_STRIP - 1)) u_strip_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .en(strip_en), .count(strip_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    s_ready      = 1'b0;
    o_conv_valid = 1'b0;
    o_conv_sel   = 1'b0;
    o_conv_d0    = '0;
    o_conv_d1    = '0;
    o_conv_d2    = '0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    cnt_clr      = 1'b0;
    kern_en      = 1'b0;
    col_en       = 1'b0;
    strip_en     = 1'b0;
    capture_p0   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          cnt_clr  = 1'b1;
          state_nx = ST_LOAD_K;
        end
      end
      ST_LOAD_K: begin
        s_ready      = 1'b1;
        o_busy       = 1'b1;
        o_conv_valid = beat;
        o_conv_d0    = s_data[BIT_LEN-1:0];
        o_conv_d1    = s_data[2*BIT_LEN-1:BIT_LEN];
        o_conv_d2    = s_data[3*BIT_LEN-1:2*BIT_LEN];
        kern_en      = beat;
        if (beat && kern_last) state_nx = ST_RUN;
      end
      ST_RUN: begin
        s_ready      = 1'b1;
        o_busy       = 1'b1;
        o_conv_sel   = 1'b1;
        o_conv_valid = beat;
        o_conv_d0    = s_data[BIT_LEN-1:0];
        o_conv_d1    = s_data[2*BIT_LEN-1:BIT_LEN];
        o_conv_d2    = s_data[3*BIT_LEN-1:2*BIT_LEN];
        col_en       = beat;
        // Columns 0..2 only prime the window; their results are stale
        capture_p0   = beat && (col_cnt >= COL_W'(CAPTURE_COL));
        if (beat && col_last) state_nx = ST_FLUSH;
      end
      ST_FLUSH: begin
        // Zero column pushes the final window's result out of the convolver
        o_busy       = 1'b1;
        o_conv_valid = 1'b1;
        o_conv_sel   = 1'b1;
        strip_en     = 1'b1;
        capture_p0   = 1'b1;
        state_nx     = strip_last ? ST_DONE : ST_RUN;
      end
      ST_DONE: begin
        o_done   = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Stage p0 -> p1: convolver result register lands one cycle after the capturing beat
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= capture_p0;
    end
  end

  assign m_valid = vld_p1;
  assign m_data  = vld_p1 ? i_conv_data : '0;

endmodule

// File: tb/tb_conv_ctrl.sv
// Bench for conv_ctrl: table-driven frames, randomized frames against a window-sum model, and corner sequences.
module tb_conv_ctrl;

  localparam int BL  = 8;
  localparam int OL  = 13;
  localparam int W1  = 5;
  localparam int NS1 = 1;
  localparam int W2  = 4;
  localparam int NS2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          i_start = 1'b0, s_valid = 1'b0, s_ready;
  logic [23:0]   s_data = '0;
  logic          o_conv_valid, o_conv_sel, m_valid, o_busy, o_done;
  logic [BL-1:0] o_conv_d0, o_conv_d1, o_conv_d2;
  logic [OL-1:0] conv_data, m_data;

  logic          i_start2 = 1'b0, s_valid2 = 1'b0, s_ready2;
  logic [23:0]   s_data2 = '0;
  logic          o_conv_valid2, o_conv_sel2, m_valid2, o_busy2, o_done2;
  logic [BL-1:0] o_conv_d0_2, o_conv_d1_2, o_conv_d2_2;
  logic [OL-1:0] conv_data2 = 13'd7, m_data2;

  conv_ctrl #(.BIT_LEN(BL), .OUT_LEN(OL), .IMG_W(W1), .N_STRIP(NS1)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .o_conv_valid(o_conv_valid), .o_conv_sel(o_conv_sel),
    .o_conv_d0(o_conv_d0), .o_conv_d1(o_conv_d1), .o_conv_d2(o_conv_d2),
    .i_conv_data(conv_data), .m_valid(m_valid), .m_data(m_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  conv_ctrl #(.BIT_LEN(BL), .OUT_LEN(OL), .IMG_W(W2), .N_STRIP(NS2)) dut2 (
    .clk(clk), .rst(rst), .i_start(i_start2), .s_valid(s_valid2), .s_ready(s_ready2),
    .s_data(s_data2), .o_conv_valid(o_conv_valid2), .o_conv_sel(o_conv_sel2),
    .o_conv_d0(o_conv_d0_2), .o_conv_d1(o_conv_d1_2), .o_conv_d2(o_conv_d2_2),
    .i_conv_data(conv_data2), .m_valid(m_valid2), .m_data(m_data2),
    .o_busy(o_busy2), .o_done(o_done2)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Environment convolver: result register holds the dot product of the window before the shift
  logic [71:0] kern_r, win_r;

  function automatic int dot(input logic [71:0] k, input logic [71:0] w);
    int s = 0;
    for (int j = 0; j < 3; j++)
      for (int r = 0; r < 3; r++)
        s += int'(k[24*j+8*r +: 8]) * int'(w[24*j+8*r +: 8]);
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      kern_r    <= '0;
      win_r     <= '0;
      conv_data <= '0;
    end else if (o_conv_valid) begin
      if (!o_conv_sel) begin
        kern_r <= {o_conv_d2, o_conv_d1, o_conv_d0, kern_r[71:24]};
      end else begin
        conv_data <= OL'(dot(kern_r, win_r));
        win_r     <= {o_conv_d2, o_conv_d1, o_conv_d0, win_r[71:24]};
      end
    end
  end

  int act_q[$];
  int exp_q[$];
  int done_cnt = 0, flush_cnt = 0;
  int mv2_cnt = 0, flush2_cnt = 0, done2_cnt = 0, bad2_data = 0;

  always @(negedge clk) begin
    if (m_valid) act_q.push_back(int'(m_data));
    if (o_done) done_cnt++;
    if (o_conv_valid && !s_ready && o_busy) begin
      flush_cnt++;
      check("flush_data", {8'd0, o_conv_d2, o_conv_d1, o_conv_d0}, 32'd0);
    end
    if (m_valid2) begin
      mv2_cnt++;
      if (m_data2 !== 13'd7) bad2_data++;
    end
    if (o_conv_valid2 && !s_ready2 && o_busy2) flush2_cnt++;
    if (o_done2) done2_cnt++;
  end

  logic [71:0] cur_kern;
  logic [23:0] cur_img[$];

  // Expected results: for each strip, a window over columns c-2..c for c = 2..IMG_W-1
  task automatic model_exp();
    exp_q.delete();
    for (int s = 0; s < NS1; s++)
      for (int c = 2; c < W1; c++) begin
        int sum = 0;
        for (int j = 0; j < 3; j++)
          for (int r = 0; r < 3; r++)
            sum += int'(cur_kern[24*j+8*r +: 8]) * int'(cur_img[s*W1 + c - 2 + j][8*r +: 8]);
        exp_q.push_back(sum % (1 << OL));
      end
  endtask

  task automatic push(input logic [23:0] d, input bit stall, input bit img, input bit poke);
    int g = 0;
    if (stall) begin
      @(negedge clk);
      if (s_ready) check("stall_conv_valid", {31'd0, o_conv_valid}, 32'd0);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b1;
    s_data  = d;
    i_start = poke;
    #1;
    while (!s_ready && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 20) check("ready_timeout", 32'd0, 32'd1);
    check("conv_valid_beat", {31'd0, o_conv_valid}, 32'd1);
    check("conv_sel", {31'd0, o_conv_sel}, {31'd0, img});
    check("conv_d1_pass", {24'd0, o_conv_d1}, {24'd0, d[15:8]});
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    i_start = 1'b0;
  endtask

  // mode: 0 continuous, 1 alternate stall, 2 random stall
  task automatic run_frame(input int mode, input bit poke, input string tag);
    int d0 = done_cnt;
    int f0 = flush_cnt;
    int g = 0;
    act_q.delete();
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    #1;
    i_start = 1'b0;
    check({tag, "_busy"}, {31'd0, o_busy}, 32'd1);
    for (int i = 0; i < 3; i++)
      push(cur_kern[24*i +: 24], (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1), 1'b0, 1'b0);
    for (int i = 0; i < cur_img.size(); i++)
      push(cur_img[i], (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1), 1'b1, poke && (i == 2));
    while (done_cnt == d0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    repeat (2) @(negedge clk);
    check({tag, "_done"}, done_cnt - d0, 1);
    check({tag, "_flush"}, flush_cnt - f0, NS1);
    check({tag, "_idle"}, {30'd0, o_busy, s_ready}, 32'd0);
  endtask

  task automatic cmp_results(input string tag);
    check({tag, "_count"}, act_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
      check($sformatf("%s_mdata%0d", tag, i), act_q[i], exp_q[i]);
  endtask

  typedef struct {
    logic [71:0]      kern;
    logic [W1*24-1:0] img;
    logic [47:0]      expv;
    int               mode;
    bit               poke;
  } vec_t;

  vec_t vecs[6];

  task automatic load_vec(input int v);
    cur_kern = vecs[v].kern;
    cur_img.delete();
    for (int i = 0; i < W1; i++) cur_img.push_back(vecs[v].img[24*i +: 24]);
    exp_q.delete();
    for (int i = 0; i < W1 - 2; i++) exp_q.push_back(int'(vecs[v].expv[16*i +: 16]));
  endtask

  initial begin
    vecs[0] = '{kern: {24'h000000, 24'h000100, 24'h000000},
                img: {24'h003200, 24'h002800, 24'h001E00, 24'h001400, 24'h000A00},
                expv: {16'd40, 16'd30, 16'd20}, mode: 0, poke: 1'b0};
    vecs[1] = vecs[0];
    vecs[1].mode = 1;
    vecs[2] = vecs[0];
    vecs[2].poke = 1'b1;
    vecs[3] = '{kern: {24'h000000, 24'h000000, 24'h000100},
                img: {24'h003200, 24'h002800, 24'h001E00, 24'h001400, 24'h000A00},
                expv: {16'd30, 16'd20, 16'd10}, mode: 0, poke: 1'b0};
    vecs[4] = '{kern: {24'h000002, 24'h000000, 24'h000000},
                img: {24'h000005, 24'h000004, 24'h000003, 24'h000002, 24'h000001},
                expv: {16'd10, 16'd8, 16'd6}, mode: 2, poke: 1'b0};
    vecs[5] = '{kern: {24'h000100, 24'h000100, 24'h000100},
                img: {24'h000500, 24'h000400, 24'h000300, 24'h000200, 24'h000100},
                expv: {16'd12, 16'd9, 16'd6}, mode: 0, poke: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_outputs", {25'd0, s_ready, o_conv_valid, o_conv_sel, m_valid, o_busy, o_done, |m_data},
          32'd0);

    for (int v = 0; v < 6; v++) begin
      load_vec(v);
      run_frame(vecs[v].mode, vecs[v].poke, $sformatf("vec%0d", v));
      cmp_results($sformatf("vec%0d", v));
    end

    for (int f = 0; f < 10; f++) begin
      cur_kern = '0;
      for (int b = 0; b < 9; b++) cur_kern[8*b +: 8] = 8'($urandom_range(0, 3));
      cur_img.delete();
      for (int i = 0; i < W1 * NS1; i++) cur_img.push_back(24'($urandom));
      model_exp();
      run_frame(2, $urandom_range(0, 1) == 1, $sformatf("rnd%0d", f));
      cmp_results($sformatf("rnd%0d", f));
    end

    // Abort after the second image beat, then a clean frame
    begin
      int d0;
      load_vec(0);
      act_q.delete();
      d0 = done_cnt;
      @(negedge clk);
      i_start = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      for (int i = 0; i < 3; i++) push(cur_kern[24*i +: 24], 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) push(cur_img[i], 1'b0, 1'b1, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("abort_outputs", {25'd0, s_ready, o_conv_valid, o_conv_sel, m_valid, o_busy, o_done, |m_data},
            32'd0);
      repeat (6) @(negedge clk);
      check("abort_no_mvalid", act_q.size(), 0);
      check("abort_no_done", done_cnt - d0, 0);
      run_frame(0, 1'b0, "post_abort");
      cmp_results("post_abort");
    end

    // Two-strip instance with an unstalled stream
    begin
      int g = 0;
      @(negedge clk);
      i_start2 = 1'b1;
      @(posedge clk);
      #1;
      i_start2 = 1'b0;
      s_valid2 = 1'b1;
      while (done2_cnt == 0 && g < 60) begin
        s_data2 = 24'($urandom);
        @(negedge clk);
        g++;
      end
      s_valid2 = 1'b0;
      repeat (3) @(negedge clk);
      check("two_strip_mvalid", mv2_cnt, (W2 - 2) * NS2);
      check("two_strip_flush", flush2_cnt, NS2);
      check("two_strip_done", done2_cnt, 1);
      check("two_strip_mdata", bad2_data, 0);
      check("two_strip_idle", {31'd0, o_busy2}, 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
